// File: rtl/hub75_rx.sv
// hub75_rx: receive-side model of a HUB75 LED panel. Rebuilds each shifted row pair
// into pixels and emits them as an addressed write stream with valid/ready handshake.
module hub75_rx #(
    parameter int unsigned COLS = 32,
    parameter int unsigned ROWS = 16
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              sclk,
    input  logic                              latch,
    input  logic                              blank,
    input  logic [2:0]                        dout_top,
    input  logic [2:0]                        dout_btm,
    input  logic [$clog2(ROWS)-1:0]           row_sel,
    output logic                              wr_vld,
    input  logic                              wr_rdy,
    output logic [$clog2(ROWS)+$clog2(COLS):0] wr_addr,
    output logic [2:0]                        wr_data,
    output logic                              row_lit,
    output logic                              frame_stb,
    output logic                              len_err,
    output logic                              ovf
);

    localparam int unsigned CW = $clog2(COLS);
    localparam int unsigned RW = $clog2(ROWS);
    localparam int unsigned BW = CW + 1;
    localparam logic [BW-1:0] CntFull = BW'(COLS);
    localparam logic [BW-1:0] CntSat  = BW'(COLS + 1);
    localparam logic [CW-1:0] ColLast = CW'(COLS - 1);
    localparam logic [RW-1:0] RowLast = RW'(ROWS - 1);

    typedef enum logic [1:0] {StIdle, StDrainTop, StDrainBtm} state_e;

    logic          sclk_q, sclk_qq, latch_q, latch_qq, blank_q;
    logic          sclk_rise_q, latch_rise_q;
    logic [2:0]    dout_top_q, dout_top_qq, dout_btm_q, dout_btm_qq;
    logic [RW-1:0] row_sel_q, row_sel_qq;

    logic [COLS-1:0][2:0] shift_top_q, shift_top_d, shift_btm_q, shift_btm_d;
    logic [COLS-1:0][2:0] hold_top_q, hold_btm_q;
    logic [RW-1:0]        hold_row_q;
    logic [BW-1:0]        bit_cnt_q, bit_cnt_d, cnt_shifted;
    logic [CW-1:0]        col_q, col_d;
    state_e               state_q, state_d;
    logic                 latch_ok, len_err_d, ovf_d, frame_d;

    // Input stage: register pins, delay once more, register edge flags with aligned data.
    // Edge-detect history resets high so a line already high at release is not an edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_q       <= 1'b1;
            sclk_qq      <= 1'b1;
            latch_q      <= 1'b1;
            latch_qq     <= 1'b1;
            blank_q      <= 1'b0;
            sclk_rise_q  <= 1'b0;
            latch_rise_q <= 1'b0;
            dout_top_q   <= '0;
            dout_top_qq  <= '0;
            dout_btm_q   <= '0;
            dout_btm_qq  <= '0;
            row_sel_q    <= '0;
            row_sel_qq   <= '0;
        end else begin
            sclk_q       <= sclk;
            sclk_qq      <= sclk_q;
            latch_q      <= latch;
            latch_qq     <= latch_q;
            blank_q      <= blank;
            sclk_rise_q  <= sclk_q & ~sclk_qq;
            latch_rise_q <= latch_q & ~latch_qq;
            dout_top_q   <= dout_top;
            dout_top_qq  <= dout_top_q;
            dout_btm_q   <= dout_btm;
            dout_btm_qq  <= dout_btm_q;
            row_sel_q    <= row_sel;
            row_sel_qq   <= row_sel_q;
        end
    end

    // Shift and bit count; a same-cycle shift is folded in before the latch is judged.
    always_comb begin
        shift_top_d = shift_top_q;
        shift_btm_d = shift_btm_q;
        cnt_shifted = bit_cnt_q;
        if (sclk_rise_q) begin
            shift_top_d = {shift_top_q[COLS-2:0], dout_top_qq};
            shift_btm_d = {shift_btm_q[COLS-2:0], dout_btm_qq};
            if (bit_cnt_q != CntSat) begin
                cnt_shifted = bit_cnt_q + BW'(1);
            end
        end
        bit_cnt_d = latch_rise_q ? '0 : cnt_shifted;
        len_err_d = latch_rise_q && (cnt_shifted != CntFull);
        ovf_d     = latch_rise_q && (cnt_shifted == CntFull) && (state_q != StIdle);
        latch_ok  = latch_rise_q && (cnt_shifted == CntFull) && (state_q == StIdle);
    end

    // Datapath registers: shift chains, hold copy of a latched row, status pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            shift_top_q <= '0;
            shift_btm_q <= '0;
            hold_top_q  <= '0;
            hold_btm_q  <= '0;
            hold_row_q  <= '0;
            bit_cnt_q   <= '0;
            row_lit     <= 1'b0;
            len_err     <= 1'b0;
            ovf         <= 1'b0;
            frame_stb   <= 1'b0;
        end else begin
            shift_top_q <= shift_top_d;
            shift_btm_q <= shift_btm_d;
            bit_cnt_q   <= bit_cnt_d;
            row_lit     <= ~blank_q;
            len_err     <= len_err_d;
            ovf         <= ovf_d;
            frame_stb   <= frame_d;
            if (latch_ok) begin
                hold_top_q <= shift_top_d;
                hold_btm_q <= shift_btm_d;
                hold_row_q <= row_sel_qq;
            end
        end
    end

    // Drain FSM state and column counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            col_q   <= '0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
        end
    end

    // Drain next-state and write-port outputs; top half first, then bottom half.
    always_comb begin
        state_d   = state_q;
        col_d     = col_q;
        wr_vld    = 1'b0;
        wr_addr   = '0;
        wr_data   = '0;
        frame_d   = 1'b0;
        case (state_q)
            StIdle: begin
                if (latch_ok) begin
                    state_d = StDrainTop;
                    col_d   = '0;
                end
            end
            StDrainTop: begin
                wr_vld  = 1'b1;
                wr_addr = {1'b0, hold_row_q, col_q};
                wr_data = hold_top_q[col_q];
                if (wr_rdy) begin
                    col_d = col_q + CW'(1);
                    if (col_q == ColLast) begin
                        col_d   = '0;
                        state_d = StDrainBtm;
                    end
                end
            end
            StDrainBtm: begin
                wr_vld  = 1'b1;
                wr_addr = {1'b1, hold_row_q, col_q};
                wr_data = hold_btm_q[col_q];
                if (wr_rdy) begin
                    col_d = col_q + CW'(1);
                    if (col_q == ColLast) begin
                        col_d   = '0;
                        state_d = StIdle;
                        frame_d = (hold_row_q == RowLast);
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

endmodule

// File: tb/tb_hub75_rx.sv
// Testbench for hub75_rx: random panel stimulus, scoreboard of expected pixel writes.
module tb_hub75_rx;

    localparam int COLS = 32;
    localparam int ROWS = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sclk = 1'b0, latch = 1'b0, blank = 1'b0;
    logic [2:0] dout_top = '0, dout_btm = '0;
    logic [3:0] row_sel = '0;
    logic       wr_vld, wr_rdy = 1'b1;
    logic [9:0] wr_addr;
    logic [2:0] wr_data;
    logic       row_lit, frame_stb, len_err, ovf;

    hub75_rx #(.COLS(COLS), .ROWS(ROWS)) dut (
        .clk(clk), .rst(rst), .sclk(sclk), .latch(latch), .blank(blank),
        .dout_top(dout_top), .dout_btm(dout_btm), .row_sel(row_sel),
        .wr_vld(wr_vld), .wr_rdy(wr_rdy), .wr_addr(wr_addr), .wr_data(wr_data),
        .row_lit(row_lit), .frame_stb(frame_stb), .len_err(len_err), .ovf(ovf)
    );

    always #5 clk = ~clk;

    int npass = 0, ntotal = 0;
    int exp_len = 0, exp_ovf = 0, exp_frame = 0;
    int obs_len = 0, obs_ovf = 0, obs_frame = 0;
    int xfer_cnt = 0;
    int rdy_mode = 0;
    logic last_flag = 1'b0;
    logic [12:0] exp_q[$];
    logic [2:0] bits_t[$], bits_b[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        ntotal++;
        if (act === exp) npass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic fail(input string name);
        ntotal++;
        $display("FAIL %s: got no completion, expected completion", name);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: a row is accepted only with exactly COLS bits and no drain pending.
    // The first bit shifted lands in the last column.
    task automatic model_latch(input logic [3:0] r);
        if (bits_t.size() != COLS) exp_len++;
        else if (exp_q.size() != 0) exp_ovf++;
        else begin
            for (int c = 0; c < COLS; c++) exp_q.push_back({1'b0, r, 5'(c), bits_t[COLS-1-c]});
            for (int c = 0; c < COLS; c++) exp_q.push_back({1'b1, r, 5'(c), bits_b[COLS-1-c]});
            if (r == 4'(ROWS - 1)) exp_frame++;
        end
        bits_t.delete();
        bits_b.delete();
    endtask

    task automatic shift_bit(input logic [2:0] t, input logic [2:0] b);
        dout_top = t;
        dout_btm = b;
        sclk = 1'b1;
        bits_t.push_back(t);
        bits_b.push_back(b);
        repeat ($urandom_range(1, 2)) tick();
        sclk = 1'b0;
        dout_top = 3'($urandom);
        dout_btm = 3'($urandom);
        repeat ($urandom_range(1, 2)) tick();
    endtask

    task automatic do_latch(input logic [3:0] r);
        row_sel = r;
        latch = 1'b1;
        model_latch(r);
        tick();
        tick();
        latch = 1'b0;
        row_sel = 4'($urandom);
        tick();
    endtask

    // Final sclk rise and latch rise on the same clk edge.
    task automatic shift_latch(input logic [2:0] t, input logic [2:0] b, input logic [3:0] r);
        dout_top = t;
        dout_btm = b;
        row_sel = r;
        sclk = 1'b1;
        latch = 1'b1;
        bits_t.push_back(t);
        bits_b.push_back(b);
        model_latch(r);
        tick();
        sclk = 1'b0;
        latch = 1'b0;
        tick();
        tick();
    endtask

    task automatic rand_row(input int nbits, input logic [3:0] r, input bit simul);
        int n;
        n = simul ? nbits - 1 : nbits;
        for (int i = 0; i < n; i++) shift_bit(3'($urandom), 3'($urandom));
        if (simul) shift_latch(3'($urandom), 3'($urandom), r);
        else do_latch(r);
    endtask

    task automatic wait_drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 3000) begin
            tick();
            n++;
        end
        if (exp_q.size() != 0) begin
            fail("drain_timeout");
            exp_q.delete();
        end
        repeat (4) tick();
    endtask

    task automatic check_pulses(input string tag);
        check({tag, "_len_err"}, 32'(obs_len), 32'(exp_len));
        check({tag, "_ovf"}, 32'(obs_ovf), 32'(exp_ovf));
        check({tag, "_frame_stb"}, 32'(obs_frame), 32'(exp_frame));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_wr_vld"}, 32'(wr_vld), 32'd0);
        check({tag, "_wr_addr"}, 32'(wr_addr), 32'd0);
        check({tag, "_wr_data"}, 32'(wr_data), 32'd0);
        check({tag, "_row_lit"}, 32'(row_lit), 32'd0);
        check({tag, "_frame_stb"}, 32'(frame_stb), 32'd0);
        check({tag, "_len_err"}, 32'(len_err), 32'd0);
        check({tag, "_ovf"}, 32'(ovf), 32'd0);
    endtask

    // Consumer ready pattern generator.
    int ph = 0;
    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0: wr_rdy = 1'b1;
                1: begin
                    wr_rdy = (ph == 0);
                    ph = (ph + 1) % 3;
                end
                2: wr_rdy = 1'($urandom);
                default: wr_rdy = 1'b0;
            endcase
        end
    end

    // Monitor: compare presented write against the scoreboard head every valid cycle,
    // pop on transfer; pulse counts and frame_stb timing.
    initial begin
        forever begin
            @(negedge clk);
            if (frame_stb || last_flag) check("frame_stb_timing", 32'(frame_stb), 32'(last_flag));
            last_flag = 1'b0;
            if (len_err) obs_len++;
            if (ovf) obs_ovf++;
            if (frame_stb) obs_frame++;
            if (wr_vld) begin
                if (exp_q.size() == 0) begin
                    ntotal++;
                    $display("FAIL unexpected_write: got addr 0x%0h, expected no write", wr_addr);
                end else begin
                    check("wr_addr", 32'(wr_addr), 32'(exp_q[0][12:3]));
                    check("wr_data", 32'(wr_data), 32'(exp_q[0][2:0]));
                    if (wr_rdy) begin
                        last_flag = (exp_q[0][12:3] == 10'h3FF);
                        void'(exp_q.pop_front());
                        xfer_cnt++;
                    end
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected end of test");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int col;
        repeat (3) tick();
        check_reset_outputs("reset");
        rst = 1'b0;

        // row_lit follows ~blank
        blank = 1'b1;
        repeat (3) tick();
        check("row_lit_blank", 32'(row_lit), 32'd0);
        blank = 1'b0;
        repeat (3) tick();
        check("row_lit_lit", 32'(row_lit), 32'd1);

        // Clean row, parity pattern on top, all-ones on bottom, row 5
        for (int i = 0; i < COLS; i++) begin
            col = COLS - 1 - i;
            shift_bit((col % 2 == 0) ? 3'b101 : 3'b010, 3'b111);
        end
        do_latch(4'd5);
        wait_drain();
        check_pulses("clean");

        // Backpressure 1,0,0,... on the same row
        rdy_mode = 1;
        for (int i = 0; i < COLS; i++) begin
            col = COLS - 1 - i;
            shift_bit((col % 2 == 0) ? 3'b101 : 3'b010, 3'b111);
        end
        do_latch(4'd5);
        wait_drain();
        rdy_mode = 0;
        check_pulses("backpressure");

        // Length errors: 31 bits, then 33 bits
        rand_row(31, 4'd3, 1'b0);
        repeat (4) tick();
        rand_row(33, 4'd3, 1'b0);
        repeat (4) tick();
        check_pulses("length");

        // Overrun while stalled
        rdy_mode = 3;
        repeat (2) tick();
        rand_row(32, 4'd1, 1'b0);
        rand_row(32, 4'd2, 1'b0);
        repeat (4) tick();
        rdy_mode = 0;
        wait_drain();
        check_pulses("overrun");

        // Full frame with coincident final sclk and latch edges
        rdy_mode = 2;
        for (int r = 0; r < ROWS; r++) begin
            rand_row(32, 4'(r), 1'b1);
            wait_drain();
        end
        check_pulses("frame");

        // Random rows, occasionally wrong length
        for (int k = 0; k < 12; k++) begin
            rand_row(($urandom_range(0, 3) == 0) ? int'($urandom_range(30, 34)) : 32,
                     4'($urandom), 1'($urandom));
            wait_drain();
        end
        check_pulses("random");

        // Reset mid-drain after 10 writes
        rdy_mode = 0;
        for (int i = 0; i < COLS; i++) shift_bit(3'($urandom), 3'($urandom));
        base = xfer_cnt;
        do_latch(4'd7);
        for (int n = 0; n < 500 && xfer_cnt < base + 10; n++) tick();
        if (xfer_cnt < base + 10) fail("reset_wait");
        rst = 1'b1;
        tick();
        check_reset_outputs("midreset");
        exp_q.delete();
        bits_t.delete();
        bits_b.delete();

        // Release reset with sclk and latch already high: no edges
        sclk = 1'b1;
        latch = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        repeat (4) tick();
        sclk = 1'b0;
        latch = 1'b0;
        repeat (3) tick();
        rand_row(32, 4'd9, 1'b0);
        wait_drain();
        check_pulses("release");
        check("final_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

endmodule
